// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13 %blockIdx,
// R14 %blockDim, R15 %threadIdx. Registered rs/rt read ports for EXECUTE,
// write-back in UPDATE, and a 13-cycle clear sequence on block dispatch.
// Optional feature macro: REGFILE_WRITE_PROTECT_EN (sticky illegal_write on
// attempted writes to R13-R15).
module thread_regfile #(
  parameter int DATA_BITS         = 8,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic                 clear,
  output logic                 busy,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic                 illegal_write
);

  localparam int          NUM_GPR   = 13;
  localparam logic [2:0]  ST_REQ    = 3'b011;
  localparam logic [2:0]  ST_UPD    = 3'b110;
  localparam logic [3:0]  LAST_GPR  = 4'd12;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [DATA_BITS-1:0] regs    [0:NUM_GPR];   // R0-R13
  logic [DATA_BITS-1:0] rf_view [0:15];
  logic [DATA_BITS-1:0] wr_data;
  logic                 clr_acc, wr_q, rd_q, wr_gpr;

  assign busy    = (state == CLEAR);
  assign clr_acc = (state == IDLE) && clear;
  assign rd_q    = enable && !busy && (core_state == ST_REQ);
  assign wr_q    = enable && !busy && (core_state == ST_UPD) &&
                   decoded_reg_write_enable && (decoded_reg_input_mux != 2'b11);
  assign wr_gpr  = wr_q && (decoded_rd_address < 4'd13);

  // Clear-sequence state and counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: one register zeroed per CLEAR cycle, leave after R12
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (clear) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_GPR) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write-back source select; reserved encoding never reaches a register
  always_comb begin
    wr_data = alu_out;
    case (decoded_reg_input_mux)
      2'b01:   wr_data = lsu_out;
      2'b10:   wr_data = decoded_immediate;
      default: wr_data = alu_out;
    endcase
  end

  // Register array: clear sequence, write-back, and %blockIdx capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_GPR; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (busy && (cnt == 4'(i)))
          regs[i] <= '0;
        else if (wr_gpr && (decoded_rd_address == 4'(i)))
          regs[i] <= wr_data;
      end
      if (clr_acc) regs[NUM_GPR] <= DATA_BITS'(block_id);
    end
  end

  // Full 16-entry read view including the constant specials
  always_comb begin
    for (int i = 0; i <= NUM_GPR; i++) rf_view[i] = regs[i];
    rf_view[14] = DATA_BITS'(THREADS_PER_BLOCK);
    rf_view[15] = DATA_BITS'(THREAD_ID);
  end

  // Registered operand ports; hold unless a qualifying REQUEST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs <= '0;
      rt <= '0;
    end else if (rd_q) begin
      rs <= rf_view[decoded_rs_address];
      rt <= rf_view[decoded_rt_address];
    end
  end

`ifdef REGFILE_WRITE_PROTECT_EN
  // Sticky flag for write attempts to R13-R15; cleared by clear acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      illegal_write <= 1'b0;
    else if (clr_acc)
      illegal_write <= 1'b0;
    else if (wr_q && (decoded_rd_address >= 4'd13))
      illegal_write <= 1'b1;
  end
`else
  assign illegal_write = 1'b0;
`endif

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile (THREADS_PER_BLOCK=4, THREAD_ID=2).
module tb_thread_regfile;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [7:0]    block_id = '0;
  logic          clear = 1'b0;
  logic          busy;
  logic [2:0]    core_state = '0;
  logic [3:0]    rd_a = '0, rs_a = '0, rt_a = '0;
  logic          we = 1'b0;
  logic [1:0]    mux = '0;
  logic [DB-1:0] imm = '0, alu = '0, lsu = '0;
  logic [DB-1:0] rs, rt;
  logic          illegal_write;

  int checks = 0;
  int fails  = 0;
  int n;
  logic exp_ill;

  thread_regfile #(.DATA_BITS(DB), .THREADS_PER_BLOCK(4), .THREAD_ID(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .clear(clear), .busy(busy), .core_state(core_state),
    .decoded_rd_address(rd_a), .decoded_rs_address(rs_a),
    .decoded_rt_address(rt_a), .decoded_reg_write_enable(we),
    .decoded_reg_input_mux(mux), .decoded_immediate(imm),
    .alu_out(alu), .lsu_out(lsu), .rs(rs), .rt(rt),
    .illegal_write(illegal_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] b);
    core_state = 3'b011; rs_a = a; rt_a = b;
    step();
    core_state = 3'b000;
  endtask

  task automatic upd(input logic [3:0] d, input logic [1:0] m,
                     input logic [DB-1:0] a, input logic [DB-1:0] l, input logic [DB-1:0] i);
    core_state = 3'b110; rd_a = d; mux = m; alu = a; lsu = l; imm = i; we = 1'b1;
    step();
    core_state = 3'b000; we = 1'b0;
  endtask

  initial begin
`ifdef REGFILE_WRITE_PROTECT_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rs", rs, 0);
    chk("rst_rt", rt, 0);
    chk("rst_ill", illegal_write, 0);
    @(negedge clk); reset = 1'b1;
    step();

    // Special registers and a fresh GPR
    req(14, 15);
    chk("r14", rs, 4);
    chk("r15", rt, 2);
    req(3, 3);
    chk("r3_rst", rs, 0);

    // Write-back sources
    upd(5, 2'b00, 8'h2A, 8'h99, 8'h98);
    req(5, 5);
    chk("alu_rs", rs, 8'h2A);
    chk("alu_rt", rt, 8'h2A);
    upd(5, 2'b01, 8'h99, 8'h11, 8'h98);
    req(5, 5);
    chk("lsu_rs", rs, 8'h11);
    upd(5, 2'b10, 8'h99, 8'h98, 8'h7F);
    req(5, 5);
    chk("imm_rs", rs, 8'h7F);
    chk("imm_rt", rt, 8'h7F);
    upd(5, 2'b11, 8'h66, 8'h66, 8'h66);
    req(5, 5);
    chk("mux11_nowrite", rs, 8'h7F);

    // Fill R0-R12 then clear
    for (int r = 0; r < 13; r++) upd(4'(r), 2'b10, 8'h00, 8'h00, 8'hFF);
    req(0, 12);
    chk("fill_r0", rs, 8'hFF);
    chk("fill_r12", rt, 8'hFF);
    block_id = 8'h09; clear = 1'b1;
    step();
    clear = 1'b0;
    // REQUEST held during busy must be ignored
    core_state = 3'b011; rs_a = 14; rt_a = 15;
    n = 0;
    while (busy && n < 40) begin
      n++;
      clear = (n == 5);
      step();
    end
    clear = 1'b0; core_state = 3'b000;
    chk("busy_cycles", n, 13);
    chk("hold_rs_busy", rs, 8'hFF);
    chk("hold_rt_busy", rt, 8'hFF);
    step();
    chk("no_requeue", busy, 0);
    req(0, 12);
    chk("clr_r0", rs, 0);
    chk("clr_r12", rt, 0);
    req(7, 13);
    chk("clr_r7", rs, 0);
    chk("r13_blk", rt, 8'h09);

    // Protected writes
    upd(14, 2'b00, 8'h55, 8'h00, 8'h00);
    chk("ill_set", illegal_write, 32'(exp_ill));
    upd(13, 2'b10, 8'h00, 8'h00, 8'h77);
    req(14, 13);
    chk("r14_prot", rs, 4);
    chk("r13_prot", rt, 8'h09);
    step(); step();
    chk("ill_sticky", illegal_write, 32'(exp_ill));

    // Disabled thread
    req(14, 14);
    enable = 1'b0;
    upd(1, 2'b10, 8'h00, 8'h00, 8'h33);
    req(1, 1);
    chk("dis_rs", rs, 4);
    chk("dis_rt", rt, 4);
    enable = 1'b1;
    req(1, 1);
    chk("en_r1", rs, 0);

    // Clear accepted while disabled, then async reset mid-sequence
    upd(2, 2'b10, 8'h00, 8'h00, 8'h44);
    req(2, 14);
    chk("pre_rs", rs, 8'h44);
    enable = 1'b0; block_id = 8'h5A; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("dis_clr_busy", busy, 1);
    chk("ill_clr", illegal_write, 0);
    for (int c = 0; c < 5; c++) step();
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rs", rs, 0);
    chk("arst_rt", rt, 0);
    #2 reset = 1'b1;
    enable = 1'b1;
    step();
    upd(5, 2'b10, 8'h00, 8'h00, 8'h21);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (busy) n++;
      step();
    end
    chk("no_resume", n, 0);
    req(13, 5);
    chk("arst_r13", rs, 0);
    chk("post_r5", rt, 8'h21);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
